// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC select encoding for the PC unit
//
// Purpose: default widths and vectors for pc_unit / pc_ras, plus the
//          next-PC source encoding used by the priority selector.
// Ports:   none (package).
package pc_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam int          INSTR_BYTES_DEF  = 4;
  localparam int          RAS_DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SEL_INC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_RET  = 3'd3,
    SEL_TRAP = 3'd4
  } next_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack
//
// Purpose: fixed-depth circular stack of return addresses. A push when full
//          overwrites the oldest entry; a pop when empty is refused.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push           push i_push_data
//   i_pop            pop the top entry
//   i_push_data      address to push
//   o_top            current top entry (valid when !o_empty)
//   o_empty, o_full  occupancy flags
//   o_overflow       strobe: push while full (oldest entry lost)
//   o_underflow      strobe: pop while empty
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_push_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // r_ptr is the next free slot; the top lives one slot below it.
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   w_top_idx;
  logic            w_do_pop;

  assign w_top_idx   = r_ptr - PW'(1);
  assign o_top       = r_mem[w_top_idx];
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign w_do_pop    = i_pop & ~o_empty;
  assign o_underflow = i_pop & o_empty;
  // Pop+push together replaces the top in place, so it never overflows.
  assign o_overflow  = i_push & ~w_do_pop & o_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_pop && !i_push) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - CW'(1);
    end else if (i_push && !w_do_pop) begin
      r_ptr   <= r_ptr + PW'(1);
      if (!o_full) r_count <= r_count + CW'(1);
    end
  end

  // Entry contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_pop && i_push) r_mem[w_top_idx] <= i_push_data;
    else if (i_push)        r_mem[r_ptr]     <= i_push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with return-address stack
//
// Purpose: holds the architectural PC and picks the next PC from
//          trap > ret > jump > branch > increment, with call/return prediction
//          through pc_ras. Optional macro MISALIGN_TRAP_EN: misaligned
//          redirects trap instead of having their low bits cleared.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_pc_write         1 = PC may advance, 0 = stall
//   i_branch_taken     PC-relative branch, i_branch_offset signed bytes
//   i_jump_valid       absolute jump to i_jump_target
//   i_call             with i_jump_valid: push return address
//   i_ret              next PC from RAS top, pop
//   i_trap             redirect to TRAP_VECTOR, overrides stall
//   o_pc_out           current PC (registered)
//   o_pc_plus          o_pc_out + INSTR_BYTES
//   o_ras_empty/full   RAS occupancy
//   o_ras_err          sticky RAS overflow/underflow
//   o_misalign         one-cycle pulse on a trapped misaligned redirect
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEF,
  parameter int              RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pc_write,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_offset,
  input  logic            i_jump_valid,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic            i_trap,
  output logic [XLEN-1:0] o_pc_out,
  output logic [XLEN-1:0] o_pc_plus,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_ras_err,
  output logic            o_misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  logic [XLEN-1:0] r_pc;
  logic            r_ras_err;
  next_sel_e       w_sel;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_ras_top;
  logic            w_update;
  logic            w_mis_trap;
  logic            w_push;
  logic            w_pop;
  logic            w_overflow;
  logic            w_underflow;

  assign o_pc_out  = r_pc;
  assign o_pc_plus = r_pc + XLEN'(INSTR_BYTES);
  assign o_ras_err = r_ras_err;
  // Trap is the only control that acts through a stall.
  assign w_update  = i_pc_write | i_trap;

  always_comb begin
    w_sel = SEL_INC;
    if (i_trap)              w_sel = SEL_TRAP;
    else if (i_ret)          w_sel = SEL_RET;
    else if (i_jump_valid)   w_sel = SEL_JMP;
    else if (i_branch_taken) w_sel = SEL_BR;
  end

  always_comb begin
    w_target = o_pc_plus;
    case (w_sel)
      SEL_TRAP: w_target = TRAP_VECTOR;
      // Return on an empty stack falls through to sequential fetch.
      SEL_RET:  w_target = o_ras_empty ? o_pc_plus : w_ras_top;
      SEL_JMP:  w_target = i_jump_target;
      SEL_BR:   w_target = r_pc + i_branch_offset;
      default:  w_target = o_pc_plus;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic w_redirect;
  logic r_misalign;
  assign w_redirect = (w_sel == SEL_RET) || (w_sel == SEL_JMP) || (w_sel == SEL_BR);
  assign w_mis_trap = w_update && w_redirect && ((w_target & ~ALIGN_MASK) != '0);
  assign o_misalign = r_misalign;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_misalign <= 1'b0;
    else          r_misalign <= w_mis_trap;
  end
`else
  assign w_mis_trap = 1'b0;
  assign o_misalign = 1'b0;
`endif

  // A misalign trap suppresses all stack activity for that redirect.
  assign w_pop  = w_update && (w_sel == SEL_RET) && !w_mis_trap;
  assign w_push = w_update && !i_trap && i_jump_valid && i_call && !w_mis_trap;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (o_pc_plus),
    .o_top       (w_ras_top),
    .o_empty     (o_ras_empty),
    .o_full      (o_ras_full),
    .o_overflow  (w_overflow),
    .o_underflow (w_underflow)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_ras_err <= 1'b0;
    end else if (w_update) begin
      r_pc      <= w_mis_trap ? TRAP_VECTOR : (w_target & ALIGN_MASK);
      r_ras_err <= r_ras_err | w_overflow | w_underflow;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        call;
  logic        ret;
  logic        trap;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  pc_unit dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pc_write      (pc_write),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_jump_valid    (jump_valid),
    .i_jump_target   (jump_target),
    .i_call          (call),
    .i_ret           (ret),
    .i_trap          (trap),
    .o_pc_out        (pc_out),
    .o_pc_plus       (pc_plus),
    .o_ras_empty     (ras_empty),
    .o_ras_full      (ras_full),
    .o_ras_err       (ras_err),
    .o_misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock, then sample just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch_taken = 0; branch_offset = '0; jump_valid = 0; jump_target = '0;
    call = 0; ret = 0; trap = 0;
  endtask

  task automatic jump(input logic [31:0] tgt, input logic is_call);
    idle();
    jump_valid = 1; jump_target = tgt; call = is_call;
    cyc();
    idle();
  endtask

  logic [31:0] rets [4];

  initial begin
    rst_n = 0; pc_write = 0;
    idle();
    #12;
    check("rst_pc", pc_out, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_full", {31'b0, ras_full}, 32'h0);
    check("rst_err", {31'b0, ras_err}, 32'h0);
    check("rst_mis", {31'b0, misalign}, 32'h0);

    // 1: sequential fetch and stall
    rst_n = 1; pc_write = 1;
    check("t1_pc0", pc_out, 32'h0);
    cyc(); check("t1_pc4", pc_out, 32'h4);
    cyc(); check("t1_pc8", pc_out, 32'h8);
    cyc(); check("t1_pcC", pc_out, 32'hC);
    pc_write = 0; branch_taken = 1; branch_offset = 32'h40;
    cyc(); check("t1_hold1", pc_out, 32'hC);
    cyc(); check("t1_hold2", pc_out, 32'hC);
    check("t1_plus", pc_plus, 32'h10);
    idle(); pc_write = 1;

    // 2: backward branch, increment wrap
    jump(32'h40, 0); check("t2_jmp", pc_out, 32'h40);
    branch_taken = 1; branch_offset = -32'sd16;
    cyc(); check("t2_br", pc_out, 32'h30);
    idle();
    jump(32'hFFFF_FFFC, 0); check("t2_top", pc_out, 32'hFFFF_FFFC);
    cyc(); check("t2_wrap", pc_out, 32'h0);

    // 3: call then return
    jump(32'h100, 0);
    jump(32'h800, 1); check("t3_call", pc_out, 32'h800);
    check("t3_nempty", {31'b0, ras_empty}, 32'h0);
    ret = 1; cyc(); idle();
    check("t3_ret", pc_out, 32'h104);
    check("t3_empty", {31'b0, ras_empty}, 32'h1);

    // 4: five calls into a four-deep stack (0x108 is overwritten)
    jump(32'h1000, 1); jump(32'h2000, 1); jump(32'h3000, 1); jump(32'h4000, 1);
    check("t4_full", {31'b0, ras_full}, 32'h1);
    check("t4_err0", {31'b0, ras_err}, 32'h0);
    jump(32'h5000, 1);
    check("t4_full2", {31'b0, ras_full}, 32'h1);
    check("t4_err1", {31'b0, ras_err}, 32'h1);
    rets[0] = 32'h4004; rets[1] = 32'h3004; rets[2] = 32'h2004; rets[3] = 32'h1004;
    for (int i = 0; i < 4; i++) begin
      ret = 1; cyc(); idle();
      check($sformatf("t4_ret%0d", i), pc_out, rets[i]);
    end
    check("t4_empty", {31'b0, ras_empty}, 32'h1);
    ret = 1; cyc(); idle();
    check("t4_ret_empty", pc_out, 32'h1008);
    check("t4_err_sticky", {31'b0, ras_err}, 32'h1);

    // 5: trap through a stall, then async reset
    jump(32'h6000, 1);
    pc_write = 0; ret = 1; trap = 1;
    cyc(); idle(); pc_write = 1;
    check("t5_trap", pc_out, 32'h100);
    check("t5_ras_kept", {31'b0, ras_empty}, 32'h0);
    ret = 1; cyc(); idle();
    check("t5_ret_after", pc_out, 32'h100C);
    cyc();
    #2 rst_n = 0;
    #1;
    check("t5_rst_pc", pc_out, 32'h0);
    check("t5_rst_err", {31'b0, ras_err}, 32'h0);
    #2 rst_n = 1;

    // 6: misaligned jump
    jump(32'h802, 0);
`ifdef MISALIGN_TRAP_EN
    check("t6_pc", pc_out, 32'h100);
    check("t6_mis", {31'b0, misalign}, 32'h1);
    cyc();
    check("t6_mis_clr", {31'b0, misalign}, 32'h0);
    check("t6_pc_next", pc_out, 32'h104);
`else
    check("t6_pc", pc_out, 32'h800);
    check("t6_mis", {31'b0, misalign}, 32'h0);
    cyc();
    check("t6_pc_next", pc_out, 32'h804);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
